clkgen_multi: RTL and testbench



---
 rtl/clkgen_multi.sv | 99 +++++++++
 tb/tb_clkgen_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_multi.sv
// clkgen_multi: NUM_CH divided clock channels from one base clock, with glitch-free
// runtime divisor updates and a power-on reset sequencer.
module clkgen_multi #(
    parameter  int NUM_CH     = 4,
    parameter  int DIV_W      = 8,
    parameter  int DEF_DIV    = 1,
    parameter  int RST_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] ch_clk,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              all_ready
);
    localparam int SEQ_W = $clog2(RST_CYCLES + 1);
    localparam logic [SEQ_W-1:0] SEQ_END = SEQ_W'(RST_CYCLES);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

    logic [NUM_CH-1:0]  pend;
    logic [2**CH_W-1:0] pend_ext;
    logic               accept;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               hold_q, hold_d, ready_q;

    // Channel numbers beyond NUM_CH read as never pending: accepted and dropped.
    always_comb begin
        pend_ext = '0;
        pend_ext[NUM_CH-1:0] = pend;
    end

    assign cfg_ready = ~pend_ext[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, pdiv_q, pdiv_d;
        logic             clk_q, clk_d, tick_q, tick_d, pend_q, pend_d;
        logic             run, tgl, apply, hit;

        // A new divisor lands only at the end of a full period (or at once when parked).
        always_comb begin
            run    = div_q != '0;
            tgl    = run && (cnt_q == div_q - 1'b1);
            apply  = pend_q && (!run || (tgl && clk_q));
            hit    = accept && (cfg_ch == CH_W'(g));
            cnt_d  = (!run || tgl) ? '0 : cnt_q + 1'b1;
            clk_d  = run && (clk_q ^ tgl);
            tick_d = tgl && !clk_q;
            div_d  = apply ? pdiv_q : div_q;
            pend_d = hit || (pend_q && !apply);
            pdiv_d = hit ? cfg_div : pdiv_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                div_q  <= DIV_RST;
                cnt_q  <= '0;
                pdiv_q <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                cnt_q  <= cnt_d;
                pdiv_q <= pdiv_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                pend_q <= pend_d;
            end
        end

        assign ch_clk[g]  = clk_q;
        assign ch_tick[g] = tick_q;
        assign pend[g]    = pend_q;
    end

    assign seq_d  = (seq_q < SEQ_END) ? seq_q + 1'b1 : seq_q;
    assign hold_d = seq_d < SEQ_END;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q   <= '0;
            hold_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            hold_q  <= hold_d;
            ready_q <= !hold_d;
        end
    end

    assign ch_rst    = {NUM_CH{hold_q}};
    assign all_ready = ready_q;
endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: table-driven reset check, then scoreboarded multi-cycle scenarios
// against a closed-form period model of each channel.
module tb_clkgen_multi;
    logic       clk = 1'b0, rst = 1'b1;
    logic       cfg_valid = 1'b0, cfg_ready;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic [3:0] ch_clk, ch_tick, ch_rst;
    logic       all_ready;
    logic       cfg_valid2 = 1'b0, cfg_ready2;
    logic [1:0] cfg_ch2 = 2'd0;
    logic [7:0] cfg_div2 = 8'd0;
    logic [2:0] ch_clk2, ch_tick2, ch_rst2;
    logic       all_ready2;

    always #5 clk = ~clk;

    clkgen_multi #(.NUM_CH(4), .DIV_W(8), .DEF_DIV(1), .RST_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .ch_clk(ch_clk), .ch_tick(ch_tick),
        .ch_rst(ch_rst), .all_ready(all_ready)
    );

    // Three channels on a 2-bit select so channel 3 is out of range.
    clkgen_multi #(.NUM_CH(3), .DIV_W(8), .DEF_DIV(1), .RST_CYCLES(16)) dut2 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
        .cfg_ch(cfg_ch2), .cfg_div(cfg_div2), .ch_clk(ch_clk2), .ch_tick(ch_tick2),
        .ch_rst(ch_rst2), .all_ready(all_ready2)
    );

    typedef struct {
        logic       rst;
        logic [3:0] clk;
        logic [3:0] tick;
        logic [3:0] crst;
        logic       rdy;
    } row_t;

    row_t       sb[$];
    row_t       tbl[23];
    int         n_chk = 0, n_pass = 0, cyc = 0, k_m = 0;
    int         dv[4], org[4], pdv[4];
    bit         pend_m[4];
    logic [3:0] tick_hist[4096];
    logic       rdy_hist[4096];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    endfunction

    function automatic bit model_ready(int ch);
        return (ch >= 4) ? 1'b1 : !pend_m[ch];
    endfunction

    // Channel level after k edges from its phase origin: high in odd multiples of div.
    function automatic row_t model_exp();
        row_t r;
        int   j;
        bit   hi;
        r.rst = rst;
        for (int i = 0; i < 4; i++) begin
            j = k_m - org[i];
            hi = (dv[i] != 0) ? ((j / dv[i]) % 2 == 1) : 1'b0;
            r.clk[i] = hi;
            r.tick[i] = (dv[i] != 0) ? (hi && (j % dv[i] == 0)) : 1'b0;
        end
        r.crst = (k_m < 16) ? 4'hF : 4'h0;
        r.rdy = k_m >= 16;
        return r;
    endfunction

    task automatic run_edge(input bit use_row, input row_t row);
        row_t e;
        bit   acc;
        #1;
        if (!rst) chk("cfg_ready", cfg_ready, model_ready(cfg_ch));
        acc = cfg_valid && model_ready(cfg_ch);
        if (rst) begin
            k_m = 0;
            for (int i = 0; i < 4; i++) begin
                dv[i] = 1; org[i] = 0; pdv[i] = 0; pend_m[i] = 0;
            end
        end else begin
            k_m++;
            for (int i = 0; i < 4; i++)
                if (pend_m[i] && ((dv[i] == 0) ? 1'b1 : ((k_m - org[i]) % (2 * dv[i]) == 0))) begin
                    dv[i] = pdv[i]; org[i] = k_m; pend_m[i] = 0;
                end
            if (acc) begin
                pend_m[cfg_ch] = 1; pdv[cfg_ch] = cfg_div;
            end
        end
        if (use_row) sb.push_back(row);
        else sb.push_back(model_exp());
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("ch_clk", ch_clk, e.clk);
        chk("ch_tick", ch_tick, e.tick);
        chk("ch_rst", ch_rst, e.crst);
        chk("all_ready", all_ready, e.rdy);
        tick_hist[cyc] = ch_tick;
        rdy_hist[cyc] = all_ready;
        cyc++;
    endtask

    task automatic step();
        row_t z;
        z = '{default: '0};
        run_edge(1'b0, z);
    endtask

    function automatic int cnt_ticks(int ch, int from, int to);
        int n = 0;
        for (int c = from; c <= to; c++) n += int'(tick_hist[c][ch]);
        return n;
    endfunction

    initial begin
        int e_t2, f_t3, g_t3, a_t4, b_t4, r_t5, guard;
        bit acc;
        for (int i = 0; i < 23; i++) begin
            tbl[i].rst  = i < 2;
            tbl[i].clk  = (i >= 2 && (i - 1) % 2 == 1) ? 4'hF : 4'h0;
            tbl[i].tick = tbl[i].clk;
            tbl[i].crst = (i < 2 || i - 1 < 16) ? 4'hF : 4'h0;
            tbl[i].rdy  = i >= 2 && i - 1 >= 16;
        end
        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst;
            run_edge(1'b1, tbl[i]);
        end
        // ch1 -> div 3 while ch1 is high
        cfg_ch = 2'd1; cfg_div = 8'd3; cfg_valid = 1'b1;
        e_t2 = cyc;
        step();
        cfg_valid = 1'b0;
        #1 chk("t2_stall", cfg_ready, 1'b0);
        for (int i = 0; i < 14; i++) step();
        chk("t2_ch0", tick_hist[e_t2 + 1][0], 1'b1);
        chk("t2_rise", tick_hist[e_t2 + 5][1], 1'b1);
        chk("t2_gap", cnt_ticks(1, e_t2 + 6, e_t2 + 10), 0);
        chk("t2_next", tick_hist[e_t2 + 11][1], 1'b1);
        // ch2 disable, then re-enable with div 5
        while (k_m % 2 != 0) step();
        cfg_ch = 2'd2; cfg_div = 8'd0; cfg_valid = 1'b1;
        f_t3 = cyc;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("t3_parked", cnt_ticks(2, f_t3 + 1, f_t3 + 14), 0);
        cfg_div = 8'd5; cfg_valid = 1'b1;
        g_t3 = cyc;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 18; i++) step();
        chk("t3_rise", tick_hist[g_t3 + 6][2], 1'b1);
        chk("t3_gap", cnt_ticks(2, g_t3 + 7, g_t3 + 15), 0);
        chk("t3_next", tick_hist[g_t3 + 16][2], 1'b1);
        // back-to-back ch0: div 4 then div 2
        while (k_m % 2 != 0) step();
        cfg_ch = 2'd0; cfg_div = 8'd4; cfg_valid = 1'b1;
        a_t4 = cyc;
        step();
        cfg_div = 8'd2;
        acc = 1'b0; guard = 0; b_t4 = -1;
        while (!acc && guard < 20) begin
            #1 acc = cfg_ready;
            b_t4 = cyc;
            step();
            guard++;
        end
        cfg_valid = 1'b0;
        chk("t4_accept", b_t4 - a_t4, 2);
        for (int i = 0; i < 16; i++) step();
        chk("t4_rise4", tick_hist[a_t4 + 5][0], 1'b1);
        chk("t4_gap", cnt_ticks(0, a_t4 + 6, a_t4 + 10), 0);
        chk("t4_rise2a", tick_hist[a_t4 + 11][0], 1'b1);
        chk("t4_rise2b", tick_hist[a_t4 + 15][0], 1'b1);
        // mid-run reset with ch1 pending
        cfg_ch = 2'd1; cfg_div = 8'd7; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0; rst = 1'b1;
        r_t5 = cyc;
        step();
        rst = 1'b0;
        #1 chk("t5_ready", cfg_ready, 1'b1);
        for (int i = 0; i < 20; i++) step();
        chk("t5_tick1", tick_hist[r_t5 + 1][1], 1'b1);
        chk("t5_tick3", tick_hist[r_t5 + 3][1], 1'b1);
        chk("t5_hold", rdy_hist[r_t5 + 15], 1'b0);
        chk("t5_rel", rdy_hist[r_t5 + 16], 1'b1);
        // out-of-range channel on the 3-channel instance
        cfg_ch2 = 2'd3; cfg_div2 = 8'd5; cfg_valid2 = 1'b1;
        #1 chk("t6_accept", cfg_ready2, 1'b1);
        step();
        cfg_valid2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_clk", ch_clk2, (k_m % 2 == 1) ? 3'b111 : 3'b000);
            chk("t6_tick", ch_tick2, (k_m % 2 == 1) ? 3'b111 : 3'b000);
            chk("t6_rst", {ch_rst2, all_ready2}, 4'b0001);
        end
        for (int c = 0; c < 4; c++) begin
            cfg_ch2 = 2'(c);
            #1 chk("t6_idle", cfg_ready2, 1'b1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
